crc_frame_checker: RTL and testbench

//  Receive-side counterpart of the CRC generator: consumes a stream of DATA_WIDTH words whose final

---
 rtl/crc_pkg.sv | 43 ++++
 rtl/crc_word_update.sv | 20 ++
 rtl/crc_frame_checker.sv | 132 +++++++++++++
 tb/tb_crc_frame_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC definitions for the generator and checker sides.
//   state_t   : checker frame FSM states
//   crc_next  : folds one data word into a CRC register, MSB of the word
//               first, non-reflected. Widths and polynomial are arguments,
//               so one function serves every instantiation. Vectors are
//               carried at CRC_MAX_W bits; the caller truncates the result.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  localparam int CRC_MAX_W = 64;

  function automatic logic [CRC_MAX_W-1:0] crc_next(
    input logic [CRC_MAX_W-1:0] crc,
    input logic [CRC_MAX_W-1:0] data,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   crc_w,
    input int                   data_w
  );
    logic [CRC_MAX_W-1:0] c;
    logic [5:0]           ci;
    logic [5:0]           di;
    logic                 fb;
    c  = crc;
    ci = 6'(crc_w - 1);
    // Fixed trip count keeps the loop statically unrollable; bits beyond
    // data_w are skipped. Bits of c above crc_w are don't-care.
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < data_w) begin
        di = 6'(data_w - 1 - i);
        fb = c[ci] ^ data[di];
        c  = c << 1;
        if (fb) c = c ^ poly;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_word_update.sv
// Combinational one-word CRC update.
//   crc_in  : current CRC register
//   data    : DATA_WIDTH word, folded MSB first
//   crc_out : CRC after the whole word has been folded in
module crc_word_update
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021
) (
  input  logic [CRC_WIDTH-1:0]  crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  assign crc_out = CRC_WIDTH'(crc_next(CRC_MAX_W'(crc_in), CRC_MAX_W'(data),
                                       CRC_MAX_W'(POLY), CRC_WIDTH, DATA_WIDTH));

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC frame checker. Payload words are folded into a CRC; the
// word flagged by s_last carries the transmitted CRC and is compared, not
// folded. The result is held on res_valid until res_ack.
//   clk, rst                      : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input word stream
//   res_valid/res_ack             : held result handshake
//   crc_ok, len_err               : pass flag, payload-overlength flag
//   crc_calc, crc_rx              : computed and received CRC
//   word_count                    : payload words (saturates at MAX_WORDS)
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] INIT       = 16'hFFFF,
  parameter int                   MAX_WORDS  = 256,
  localparam int                  CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  res_valid,
  input  logic                  res_ack,
  output logic                  crc_ok,
  output logic                  len_err,
  output logic [CRC_WIDTH-1:0]  crc_calc,
  output logic [CRC_WIDTH-1:0]  crc_rx,
  output logic [CNT_W-1:0]      word_count
);

  state_t               state;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] crc_upd;
  logic [CRC_WIDTH-1:0] rx_word;
  logic                 xfer;

  assign xfer     = s_valid && s_ready;
  assign rx_word  = s_data[CRC_WIDTH-1:0];
  assign crc_calc = crc_reg;

  // crc_reg sits at INIT whenever the FSM is in IDLE, so the same update
  // path serves the first payload word and every later one.
  crc_word_update #(
    .DATA_WIDTH(DATA_WIDTH),
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY)
  ) u_word_update (
    .crc_in (crc_reg),
    .data   (s_data),
    .crc_out(crc_upd)
  );

  // NOTE: state is assigned with <= only, so every read in this block sees
  // the pre-edge value; later assignments to the same register override
  // earlier defaults within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      res_valid  <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      crc_reg    <= INIT;
      crc_rx     <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // s_ready rises one cycle after reset release.
          s_ready <= 1'b1;
          if (xfer) begin
            if (s_last) begin
              // Empty payload: compare against the untouched seed.
              state     <= REPORT;
              s_ready   <= 1'b0;
              res_valid <= 1'b1;
              crc_rx    <= rx_word;
              crc_ok    <= (crc_reg == rx_word);
            end else begin
              state      <= ACCUM;
              crc_reg    <= crc_upd;
              word_count <= CNT_W'(1);
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            if (s_last) begin
              state     <= REPORT;
              s_ready   <= 1'b0;
              res_valid <= 1'b1;
              crc_rx    <= rx_word;
              crc_ok    <= (crc_reg == rx_word) && !len_err;
            end else begin
              crc_reg <= crc_upd;
              // A word arriving with the count already at MAX_WORDS is
              // the overlength word; the count saturates from here on.
              if (word_count == CNT_W'(MAX_WORDS)) begin
                len_err <= 1'b1;
              end else begin
                word_count <= word_count + CNT_W'(1);
              end
            end
          end
        end

        REPORT: begin
          if (res_ack) begin
            state      <= IDLE;
            s_ready    <= 1'b1;
            res_valid  <= 1'b0;
            crc_ok     <= 1'b0;
            len_err    <= 1'b0;
            word_count <= '0;
            crc_reg    <= INIT;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: directed table, multi-cycle
// corner sequences and randomized frames against a polynomial-division model.
module tb_crc_frame_checker;

  localparam int MAX_WORDS = 256;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             s_last;
  logic             res_valid;
  logic             res_ack;
  logic             crc_ok;
  logic             len_err;
  logic [15:0]      crc_calc;
  logic [15:0]      crc_rx;
  logic [CNT_W-1:0] word_count;

  crc_frame_checker #(
    .DATA_WIDTH(16),
    .CRC_WIDTH (16),
    .POLY      (16'h1021),
    .INIT      (16'hFFFF),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .crc_ok    (crc_ok),
    .len_err   (len_err),
    .crc_calc  (crc_calc),
    .crc_rx    (crc_rx),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC: the frame is treated as one long bit string M of n bits.
  // Seeding with INIT equals XORing INIT into the first 16 message bits;
  // the CRC is then (M' * x^16) mod G found by plain long division.
  function automatic logic [15:0] model_crc(input logic [15:0] words[$]);
    bit          b[$];
    logic [15:0] init_v;
    logic [16:0] gen;
    logic [16:0] r;
    init_v = 16'hFFFF;
    gen    = 17'h11021;
    foreach (words[i])
      for (int k = 15; k >= 0; k--) b.push_back(words[i][k]);
    if (b.size() == 0) return init_v;
    for (int k = 0; k < 16; k++) b[k] = b[k] ^ init_v[15-k];
    for (int k = 0; k < 16; k++) b.push_back(1'b0);
    r = '0;
    foreach (b[i]) begin
      r = {r[15:0], b[i]};
      if (r[16]) r = r ^ gen;
    end
    return r[15:0];
  endfunction

  // Called and returns at a falling edge; the word is taken on the rising
  // edge in between.
  task automatic send_word(input logic [15:0] d, input logic last, input int gap);
    int budget;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    budget  = 0;
    while (!s_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) begin
      check("accept_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] words[$], input logic [15:0] crcw, input int maxgap);
    foreach (words[i]) send_word(words[i], 1'b0, $urandom_range(0, maxgap));
    send_word(crcw, 1'b1, $urandom_range(0, maxgap));
  endtask

  task automatic check_result(input string tag, input logic [15:0] calc, input logic [15:0] rx,
                              input logic ok, input logic lerr, input int cnt, input int ack_delay);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    repeat (ack_delay) @(negedge clk);
    check({tag, "_crc_calc"}, 32'(crc_calc), 32'(calc));
    check({tag, "_crc_rx"}, 32'(crc_rx), 32'(rx));
    check({tag, "_crc_ok"}, 32'(crc_ok), 32'(ok));
    check({tag, "_len_err"}, 32'(len_err), 32'(lerr));
    check({tag, "_word_count"}, 32'(word_count), 32'(cnt));
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check({tag, "_cleared"}, {res_valid, s_ready, crc_ok, len_err, 16'(word_count)},
          {1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
    check({tag, "_reseed"}, 32'(crc_calc), 32'hFFFF);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_flags"}, {s_ready, res_valid, crc_ok, len_err}, 32'd0);
    check({tag, "_crc_calc"}, 32'(crc_calc), 32'hFFFF);
    check({tag, "_crc_rx"}, 32'(crc_rx), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] w;
    logic [15:0] crcw;
    logic [15:0] calc;
    logic        ok;
    int          cnt;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[4];
    logic [15:0] q[$];
    logic [15:0] good;
    logic [15:0] crcw;
    int          len;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; res_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(s_ready), 32'd1);

    // Directed table: empty frames and single zero word.
    tbl[0] = '{0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 0};
    tbl[1] = '{0, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 0};
    tbl[2] = '{1, 16'h0000, 16'h1D0F, 16'h1D0F, 1'b1, 1};
    tbl[3] = '{1, 16'h0000, 16'h1D0E, 16'h1D0F, 1'b0, 1};
    for (int t = 0; t < 4; t++) begin
      q.delete();
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].w);
      send_frame(q, tbl[t].crcw, 0);
      check_result($sformatf("tbl%0d", t), tbl[t].calc, tbl[t].crcw, tbl[t].ok, 1'b0, tbl[t].cnt, 0);
    end

    // Backpressure: result held while a new word waits, then accepted right after ack.
    q.delete(); q.push_back(16'h0000);
    send_frame(q, 16'h1D0F, 0);
    s_valid = 1'b1; s_data = 16'h0000; s_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {s_ready, res_valid, crc_ok, crc_calc, crc_rx},
            {1'b0, 1'b1, 1'b1, 16'h1D0F, 16'h1D0F});
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("bp_ack", {s_ready, res_valid}, {1'b1, 1'b0});
    @(negedge clk);
    s_valid = 1'b0;
    send_word(16'h1D0F, 1'b1, 0);
    check_result("bp_next", 16'h1D0F, 16'h1D0F, 1'b1, 1'b0, 1, 0);

    // Overlength: MAX_WORDS+1 payload words with the correct CRC still fails.
    q.delete();
    for (int i = 0; i <= MAX_WORDS; i++) q.push_back(16'($urandom));
    good = model_crc(q);
    send_frame(q, good, 0);
    check_result("overlen", good, good, 1'b0, 1'b1, MAX_WORDS, 1);

    // Reset after 3 of 5 words: no result, reset values, then a clean frame.
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'b0, 0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q.delete(); q.push_back(16'h0000);
    send_frame(q, 16'h1D0F, 0);
    check_result("postrst", 16'h1D0F, 16'h1D0F, 1'b1, 1'b0, 1, 0);

    // Random frames with gaps, corruption and delayed acks.
    for (int f = 0; f < 25; f++) begin
      if (f == 0) len = MAX_WORDS;
      else if ($urandom_range(0, 3) == 0) len = $urandom_range(0, MAX_WORDS);
      else len = $urandom_range(0, 12);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(16'($urandom));
      good = model_crc(q);
      crcw = good;
      if ($urandom_range(0, 2) == 0) crcw = good ^ (16'd1 << $urandom_range(0, 15));
      send_frame(q, crcw, 2);
      check_result($sformatf("rand%0d", f), good, crcw, crcw == good, 1'b0, len,
                   $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
